// File: rtl/div_sign_ctrl.sv
// div_sign_ctrl
//   Issue/retire stage wrapped around a 32-bit unsigned sequential divider core.
//   Accepts a signed or unsigned operand pair, answers divide-by-zero and
//   INT_MIN/-1 directly, and otherwise feeds operand magnitudes to the core.
//   When the core finishes, the stage sign-corrects the result and holds it
//   on a valid/ready output.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             operand handshake (dividend, divisor, is_signed)
//   core_start/core_x/core_y      start level and operand magnitudes to the core
//   core_done/core_quotient/
//   core_remainder                core completion level and unsigned results
//   out_valid/out_ready           result handshake (quotient, remainder, flags)
//   div_by_zero/overflow/timeout  mutually exclusive result flags
//   busy                          high whenever an operation is in flight
module div_sign_ctrl #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_W          = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        is_signed,
   output logic        core_start,
   output logic [31:0] core_x,
   output logic [31:0] core_y,
   input  logic        core_done,
   input  logic [31:0] core_quotient,
   input  logic [31:0] core_remainder,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero,
   output logic        overflow,
   output logic        timeout,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_WAIT, S_FIX, S_OUT} state_t;

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

   state_t            state, state_nxt;
   logic [31:0]       a_q, b_q;
   logic              s_q;
   logic              neg_q, neg_r;
   logic [31:0]       q_raw, r_raw;
   logic [CNT_W-1:0]  wdog;
   logic              done_q;

   logic accept, done_edge, wd_expire, dz_in, ov_in;

   assign accept    = in_valid & in_ready;
   // done_q follows core_done every cycle, so a level already high when WAIT
   // is entered never looks like an edge.
   assign done_edge = core_done & ~done_q;
   // wdog counts completed WAIT cycles; the op aborts on the cycle that
   // would bring it to TIMEOUT_CYCLES.
   assign wd_expire = (wdog + 1'b1) == TO_LIM;
   assign dz_in     = (divisor == 32'd0);
   assign ov_in     = is_signed & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = (dz_in | ov_in) ? S_OUT : S_PREP;
         S_PREP: state_nxt = S_WAIT;
         S_WAIT: begin
            if (done_edge)      state_nxt = S_FIX;
            else if (wd_expire) state_nxt = S_OUT;
         end
         S_FIX:  state_nxt = S_OUT;
         S_OUT:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // state-decoded outputs; in_ready is gated by rst so every output is 0 in reset
   always_comb begin
      in_ready   = (state == S_IDLE) & ~rst;
      core_start = (state == S_WAIT);
      out_valid  = (state == S_OUT);
      busy       = (state != S_IDLE);
   end

   // datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         q_raw       <= '0;
         r_raw       <= '0;
         wdog        <= '0;
         done_q      <= 1'b0;
         core_x      <= '0;
         core_y      <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         done_q <= core_done;
         case (state)
            S_IDLE: if (accept) begin
               a_q <= dividend;
               b_q <= divisor;
               s_q <= is_signed;
               if (dz_in) begin
                  quotient    <= 32'hFFFF_FFFF;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end else if (ov_in) begin
                  quotient    <= 32'h8000_0000;
                  remainder   <= '0;
                  overflow    <= 1'b1;
               end else begin
                  wdog <= '0;
               end
            end
            S_PREP: begin
               // -0x80000000 wraps to itself, which is the correct unsigned 2^31
               core_x <= (s_q & a_q[31]) ? -a_q : a_q;
               core_y <= (s_q & b_q[31]) ? -b_q : b_q;
               neg_q  <= s_q & (a_q[31] ^ b_q[31]);
               neg_r  <= s_q & a_q[31];
            end
            S_WAIT: begin
               wdog <= wdog + 1'b1;
               if (done_edge) begin
                  q_raw <= core_quotient;
                  r_raw <= core_remainder;
               end else if (wd_expire) begin
                  quotient  <= '0;
                  remainder <= '0;
                  timeout   <= 1'b1;
               end
            end
            S_FIX: begin
               quotient  <= neg_q ? -q_raw : q_raw;
               remainder <= neg_r ? -r_raw : r_raw;
            end
            S_OUT: if (out_ready) begin
               div_by_zero <= 1'b0;
               overflow    <= 1'b0;
               timeout     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Bench for div_sign_ctrl: directed vector table plus hand-written sequences
// for backpressure, timeout, sticky core_done and reset mid-operation.
// The divider core is modelled behaviourally with a programmable latency.
module tb_div_sign_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] dividend, divisor;
   logic        is_signed;
   logic        core_start;
   logic [31:0] core_x, core_y;
   logic        core_done = 1'b0;
   logic [31:0] core_quotient = '0, core_remainder = '0;
   logic        out_valid, out_ready;
   logic [31:0] quotient, remainder;
   logic        div_by_zero, overflow, timeout, busy;

   div_sign_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
      .core_start(core_start), .core_x(core_x), .core_y(core_y),
      .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow), .timeout(timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   // core model: done rises core_lat cycles into core_start; stick keeps it high
   int core_lat = 10;
   bit core_en  = 1'b1;
   bit stick    = 1'b0;
   int ccnt     = 0;
   always @(posedge clk) begin
      if (!core_start) begin
         ccnt <= 0;
         if (!stick) core_done <= 1'b0;
      end else begin
         ccnt <= ccnt + 1;
         if (core_en && (ccnt + 1 == core_lat) && core_y != 0) begin
            core_done      <= 1'b1;
            core_quotient  <= core_x / core_y;
            core_remainder <= core_x % core_y;
         end
      end
   end

   int n_pass = 0, n_tot = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   logic [31:0] r_q, r_r, r_cx, r_cy;
   logic [2:0]  r_fl;
   int          r_lat, r_wc;

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      int guard = 0;
      r_lat = 0; r_wc = 0; r_cx = '0; r_cy = '0;
      while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      r_lat = 1;
      while (!out_valid && r_lat < 200) begin
         if (core_start) begin
            if (r_wc == 0) begin r_cx = core_x; r_cy = core_y; end
            r_wc++;
         end
         @(posedge clk); #1;
         r_lat++;
      end
      chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
      r_q = quotient; r_r = remainder; r_fl = {div_by_zero, overflow, timeout};
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk("retire_out_valid", {31'd0, out_valid}, 32'd0);
      chk("retire_in_ready", {31'd0, in_ready}, 32'd1);
      chk("retire_flags", {29'd0, div_by_zero, overflow, timeout}, 32'd0);
   endtask

   typedef struct {
      logic [31:0] a, b;
      logic        s, byp;
      logic [31:0] x, y, q, r;
      logic [2:0]  fl;   // {div_by_zero, overflow, timeout}
   } vec_t;
   vec_t vt[10];

   initial begin
      vt[0] = '{32'd4802,       32'd172,        1'b0, 1'b0, 32'd4802,       32'd172,        32'd27,         32'd158,        3'b000};
      vt[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'd7,          32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  3'b000};
      vt[2] = '{32'd100,        32'd0,          1'b0, 1'b1, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd100,        3'b100};
      vt[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0,          32'd0,          32'h8000_0000,  32'd0,          3'b010};
      vt[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  3'b000};
      vt[5] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, 32'd7,          32'd2,          32'hFFFF_FFFD,  32'd1,          3'b000};
      vt[6] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 1'b0, 32'd7,          32'd2,          32'd3,          32'hFFFF_FFFF,  3'b000};
      vt[7] = '{32'h8000_0000,  32'd2,          1'b1, 1'b0, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          3'b000};
      vt[8] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 1'b1, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  3'b100};
      vt[9] = '{32'hFFFF_FFFF,  32'd10,         1'b0, 1'b0, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5,          3'b000};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0; is_signed = 1'b0;
      #1;
      chk("rst_in_ready",   {31'd0, in_ready},   32'd0);
      chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
      chk("rst_core_start", {31'd0, core_start}, 32'd0);
      chk("rst_busy",       {31'd0, busy},       32'd0);
      chk("rst_quotient",   quotient,            32'd0);
      chk("rst_flags",      {29'd0, div_by_zero, overflow, timeout}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // vector table
      for (int i = 0; i < 10; i++) begin
         run_op(vt[i].a, vt[i].b, vt[i].s);
         chk($sformatf("v%0d_quotient", i), r_q, vt[i].q);
         chk($sformatf("v%0d_remainder", i), r_r, vt[i].r);
         chk($sformatf("v%0d_flags", i), {29'd0, r_fl}, {29'd0, vt[i].fl});
         if (vt[i].byp) begin
            chk($sformatf("v%0d_bypass_latency", i), r_lat, 32'd1);
            chk($sformatf("v%0d_bypass_nostart", i), r_wc, 32'd0);
         end else begin
            chk($sformatf("v%0d_core_x", i), r_cx, vt[i].x);
            chk($sformatf("v%0d_core_y", i), r_cy, vt[i].y);
            chk($sformatf("v%0d_latency", i), r_lat, r_wc + 3);
         end
         retire();
      end

      // backpressure: hold out_ready low 5 cycles, retire on the 6th
      run_op(32'd4802, 32'd172, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
         chk("bp_quotient",  quotient,  32'd27);
         chk("bp_remainder", remainder, 32'd158);
      end
      retire();

      // timeout with core never finishing
      core_en = 1'b0;
      run_op(32'd50, 32'd7, 1'b0);
      chk("to_flags", {29'd0, r_fl}, 32'b001);
      chk("to_quotient", r_q, 32'd0);
      chk("to_remainder", r_r, 32'd0);
      chk("to_wait_cycles", r_wc, 32'd16);
      chk("to_core_start", {31'd0, core_start}, 32'd0);
      retire();
      core_en = 1'b1;

      // sticky core_done from the previous op must not complete the next one
      stick = 1'b1;
      run_op(32'd10, 32'd3, 1'b0);
      chk("st1_quotient", r_q, 32'd3);
      chk("st1_remainder", r_r, 32'd1);
      retire();
      chk("st_done_high", {31'd0, core_done}, 32'd1);
      run_op(32'd20, 32'd3, 1'b0);
      chk("st2_flags", {29'd0, r_fl}, 32'b001);
      chk("st2_wait_cycles", r_wc, 32'd16);
      retire();
      stick = 1'b0;
      repeat (2) @(posedge clk); #1;
      run_op(32'd20, 32'd3, 1'b0);
      chk("st3_quotient", r_q, 32'd6);
      chk("st3_remainder", r_r, 32'd2);
      chk("st3_flags", {29'd0, r_fl}, 32'd0);
      retire();

      // reset in the middle of WAIT
      dividend = 32'd10; divisor = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      begin
         int g = 0;
         while (!core_start && g < 20) begin @(posedge clk); #1; g++; end
      end
      chk("mr_in_wait", {31'd0, core_start}, 32'd1);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mr_core_start", {31'd0, core_start}, 32'd0);
      chk("mr_busy",       {31'd0, busy},       32'd0);
      chk("mr_out_valid",  {31'd0, out_valid},  32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("mr_idle_out_valid", {31'd0, out_valid}, 32'd0);
      run_op(32'd10, 32'd3, 1'b0);
      chk("mr_quotient", r_q, 32'd3);
      chk("mr_remainder", r_r, 32'd1);
      chk("mr_flags", {29'd0, r_fl}, 32'd0);
      retire();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
